// File: rtl/riscv_selftest_checker.sv
// riscv_selftest_checker
//   On-chip self-test checker for the single-cycle RISC-V core. Mirrors
//   architectural register writes into a shadow file while the test program
//   runs. It ends the run on a halt instruction or on a cycle timeout. It then
//   scans the shadow file against a loadable expected-value table and reports
//   pass/fail counts and drives the RGB LED.
//
// Ports
//   clk, reset         clock; synchronous active-low reset
//   start              one-cycle pulse, begins a run from IDLE or DONE
//   instr_valid        core retired an instruction this cycle
//   instruction        current instruction word (halt detection)
//   rf_we/waddr/wdata  core register-file write port (mirrored)
//   exp_we/idx/data/en expected-table write port (IDLE/DONE only)
//   busy, done, pass   run status; pass is meaningful while done
//   timeout            run was ended by the cycle limit
//   check_count        number of table entries compared
//   fail_count         number of mismatching entries
//   first_fail_*       lowest mismatching index
//   led_red/green/blue fail / pass / busy indicators
//
//   state | meaning
//   IDLE  | waiting for start, expected table writable
//   RUN   | mirroring core writes, counting retired instructions
//   SCAN  | comparing one shadow entry per cycle against the table
//   DONE  | results held, table writable, start reruns
module riscv_selftest_checker #(
  parameter int          XLEN            = 32,
  parameter int          NREGS           = 32,
  parameter int          MAX_CYCLES      = 50,
  parameter int          HALT_GRACE      = 5,
  parameter logic [31:0] HALT_INSTR      = 32'h0000_006F,
  parameter bit          TIMEOUT_IS_FAIL = 1'b1,
  localparam int         AW              = $clog2(NREGS),
  localparam int         CW              = $clog2(NREGS + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            instr_valid,
  input  logic [31:0]     instruction,
  input  logic            rf_we,
  input  logic [AW-1:0]   rf_waddr,
  input  logic [XLEN-1:0] rf_wdata,
  input  logic            exp_we,
  input  logic [AW-1:0]   exp_idx,
  input  logic [XLEN-1:0] exp_data,
  input  logic            exp_en,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            timeout,
  output logic [CW-1:0]   check_count,
  output logic [CW-1:0]   fail_count,
  output logic            first_fail_valid,
  output logic [AW-1:0]   first_fail_idx,
  output logic            led_red,
  output logic            led_green,
  output logic            led_blue
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SCAN,
    S_DONE
  } state_t;

  localparam logic [31:0]   CYC_LAST = 32'(MAX_CYCLES - 1);
  localparam logic [31:0]   GRACE    = 32'(HALT_GRACE);
  localparam logic [AW-1:0] IDX_LAST = AW'(NREGS - 1);

  state_t          state;
  state_t          state_next;
  logic [31:0]     cyc_cnt;
  logic [AW-1:0]   scan_idx;
  logic [XLEN-1:0] shadow   [NREGS];
  logic [XLEN-1:0] exp_val  [NREGS];
  logic [NREGS-1:0] exp_mask;

  logic            halt_hit;
  logic            tmo_hit;
  logic [XLEN-1:0] scan_val;
  logic            scan_miss;
  logic            verdict;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    halt_hit   = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_next = S_RUN;
      end
      S_RUN: begin
        // cyc_cnt is the count before this instruction; halt wins over timeout
        if (instr_valid) begin
          if (instruction == HALT_INSTR && cyc_cnt > GRACE) halt_hit = 1'b1;
          else if (cyc_cnt == CYC_LAST)                     tmo_hit  = 1'b1;
        end
        if (halt_hit || tmo_hit) state_next = S_SCAN;
      end
      S_SCAN: begin
        if (scan_idx == IDX_LAST) state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // x0 is architecturally zero, so its expected entry is checked against 0
  assign scan_val  = (scan_idx == '0) ? '0 : shadow[scan_idx];
  assign scan_miss = exp_mask[scan_idx] && (scan_val != exp_val[scan_idx]);
  assign verdict   = (fail_count == '0) && !(TIMEOUT_IS_FAIL && timeout);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        shadow[i]  <= '0;
        exp_val[i] <= '0;
      end
      exp_mask         <= '0;
      cyc_cnt          <= '0;
      scan_idx         <= '0;
      timeout          <= 1'b0;
      check_count      <= '0;
      fail_count       <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      led_red          <= 1'b0;
      led_green        <= 1'b0;
      led_blue         <= 1'b0;
    end else begin
      // status outputs are registered copies of the current state
      busy      <= (state == S_RUN) || (state == S_SCAN);
      led_blue  <= (state == S_RUN) || (state == S_SCAN);
      done      <= (state == S_DONE);
      pass      <= (state == S_DONE) && verdict;
      led_green <= (state == S_DONE) && verdict;
      led_red   <= (state == S_DONE) && !verdict;

      case (state)
        S_IDLE, S_DONE: begin
          if (exp_we) begin
            exp_val[exp_idx]  <= exp_data;
            exp_mask[exp_idx] <= exp_en;
          end
          if (start) begin
            for (int i = 0; i < NREGS; i++) shadow[i] <= '0;
            cyc_cnt          <= '0;
            scan_idx         <= '0;
            timeout          <= 1'b0;
            check_count      <= '0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
          end
        end
        S_RUN: begin
          if (rf_we && rf_waddr != '0) shadow[rf_waddr] <= rf_wdata;
          if (instr_valid) cyc_cnt <= cyc_cnt + 32'd1;
          if (tmo_hit) timeout <= 1'b1;
        end
        S_SCAN: begin
          if (exp_mask[scan_idx]) check_count <= check_count + 1'b1;
          if (scan_miss) begin
            fail_count <= fail_count + 1'b1;
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_idx   <= scan_idx;
            end
          end
          scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_selftest_checker.sv
module tb_riscv_selftest_checker;

  localparam int          NREGS = 32;
  localparam int          XLEN  = 32;
  localparam int          AW    = 5;
  localparam int          CW    = 6;
  localparam int          MAXC  = 50;
  localparam int          GRACE = 5;
  localparam logic [31:0] HALT  = 32'h0000_006F;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            instr_valid = 1'b0;
  logic [31:0]     instruction = '0;
  logic            rf_we = 1'b0;
  logic [AW-1:0]   rf_waddr = '0;
  logic [XLEN-1:0] rf_wdata = '0;
  logic            exp_we = 1'b0;
  logic [AW-1:0]   exp_idx = '0;
  logic [XLEN-1:0] exp_data = '0;
  logic            exp_en = 1'b0;

  logic a_busy, a_done, a_pass, a_timeout, a_ffv, a_red, a_green, a_blue;
  logic [CW-1:0] a_chk, a_fail;
  logic [AW-1:0] a_ffi;
  logic b_busy, b_done, b_pass, b_timeout, b_ffv, b_red, b_green, b_blue;
  logic [CW-1:0] b_chk, b_fail;
  logic [AW-1:0] b_ffi;

  riscv_selftest_checker #(.TIMEOUT_IS_FAIL(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .instr_valid(instr_valid),
    .instruction(instruction), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_data(exp_data), .exp_en(exp_en),
    .busy(a_busy), .done(a_done), .pass(a_pass), .timeout(a_timeout),
    .check_count(a_chk), .fail_count(a_fail), .first_fail_valid(a_ffv),
    .first_fail_idx(a_ffi), .led_red(a_red), .led_green(a_green), .led_blue(a_blue)
  );

  riscv_selftest_checker #(.TIMEOUT_IS_FAIL(1'b0)) dut_nt (
    .clk(clk), .reset(reset), .start(start), .instr_valid(instr_valid),
    .instruction(instruction), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_data(exp_data), .exp_en(exp_en),
    .busy(b_busy), .done(b_done), .pass(b_pass), .timeout(b_timeout),
    .check_count(b_chk), .fail_count(b_fail), .first_fail_valid(b_ffv),
    .first_fail_idx(b_ffi), .led_red(b_red), .led_green(b_green), .led_blue(b_blue)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: expected table, shadow registers, retired count, timeout
  logic [31:0] m_exp [NREGS];
  logic [31:0] m_sh  [NREGS];
  bit          m_en  [NREGS];
  int          m_cyc;
  bit          m_tmo;

  typedef struct {
    logic [31:0] w1, w2, w3;
    int          fails;
    bit          ffv;
    int          ffi;
    bit          ok;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear_table();
    for (int i = 0; i < NREGS; i++) begin
      m_exp[i] = '0;
      m_en[i]  = 1'b0;
    end
  endtask

  task automatic load(input int idx, input logic [31:0] d, input bit en);
    exp_we   = 1'b1;
    exp_idx  = AW'(idx);
    exp_data = d;
    exp_en   = en;
    step();
    exp_we   = 1'b0;
    m_exp[idx] = d;
    m_en[idx]  = en;
  endtask

  task automatic begin_run();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < NREGS; i++) m_sh[i] = '0;
    m_cyc = 0;
    m_tmo = 1'b0;
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input bit we,
                       input int addr, input logic [31:0] d, output bit ended);
    instr_valid = v;
    instruction = ins;
    rf_we       = we;
    rf_waddr    = AW'(addr);
    rf_wdata    = d;
    ended = 1'b0;
    if (v) begin
      if (ins == HALT && m_cyc > GRACE) ended = 1'b1;
      else if (m_cyc == MAXC - 1) begin
        ended = 1'b1;
        m_tmo = 1'b1;
      end
      m_cyc++;
    end
    if (we && addr != 0) m_sh[addr] = d;
    step();
    instr_valid = 1'b0;
    instruction = '0;
    rf_we       = 1'b0;
  endtask

  // called right after the edge that ended the run
  task automatic finish_check(input string tag);
    int lat;
    int e_chk, e_fail, e_ffi;
    bit e_ffv, e_pass_a, e_pass_b;
    logic [31:0] v;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (a_done) begin
        lat = k;
        break;
      end
    end
    chk({tag, "/latency"}, lat, NREGS + 1);
    e_chk = 0; e_fail = 0; e_ffv = 1'b0; e_ffi = 0;
    for (int i = 0; i < NREGS; i++) begin
      if (m_en[i]) begin
        e_chk++;
        v = (i == 0) ? 32'd0 : m_sh[i];
        if (v != m_exp[i]) begin
          e_fail++;
          if (!e_ffv) begin
            e_ffv = 1'b1;
            e_ffi = i;
          end
        end
      end
    end
    e_pass_a = (e_fail == 0) && !m_tmo;
    e_pass_b = (e_fail == 0);
    chk({tag, "/check_count"}, a_chk, e_chk);
    chk({tag, "/fail_count"}, a_fail, e_fail);
    chk({tag, "/ff_valid"}, a_ffv, e_ffv);
    chk({tag, "/ff_idx"}, a_ffi, e_ffi);
    chk({tag, "/timeout"}, a_timeout, m_tmo);
    chk({tag, "/pass"}, a_pass, e_pass_a);
    chk({tag, "/leds"}, {a_red, a_green, a_blue, a_busy}, {!e_pass_a, e_pass_a, 2'b00});
    chk({tag, "/nt_done"}, b_done, 1'b1);
    chk({tag, "/nt_pass"}, b_pass, e_pass_b);
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, {a_busy, a_done, a_pass, a_timeout, a_chk, a_fail, a_ffv, a_ffi,
              a_red, a_green, a_blue}, '0);
  endtask

  // correct x1..x3 writes, x0 poke, halt at cyc 6 with x5=7 in the halt cycle
  task automatic x0_run();
    bit e;
    begin_run();
    drive(1, NOP, 1, 1, 32'd5, e);
    drive(1, NOP, 1, 2, 32'd10, e);
    drive(1, NOP, 1, 3, 32'd15, e);
    drive(1, NOP, 1, 0, 32'hDEADBEEF, e);
    drive(1, NOP, 0, 0, 0, e);
    drive(1, NOP, 0, 0, 0, e);
    drive(1, HALT, 1, 5, 32'd7, e);
  endtask

  task automatic good_run();
    bit e;
    begin_run();
    drive(1, NOP, 1, 1, 32'd5, e);
    drive(1, NOP, 1, 2, 32'd10, e);
    drive(1, NOP, 1, 3, 32'd15, e);
    for (int i = 0; i < 3; i++) drive(1, NOP, 0, 0, 0, e);
    drive(1, HALT, 0, 0, 0, e);
  endtask

  task automatic random_run(input int r);
    bit e, v, we;
    logic [31:0] ins;
    e = 1'b0;
    for (int i = 0; i < NREGS; i++)
      load(i, 32'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    begin_run();
    for (int c = 0; c < 400 && !e; c++) begin
      v   = ($urandom_range(0, 4) != 0);
      ins = ($urandom_range(0, 11) == 0) ? HALT : ($urandom | 32'h100);
      we  = 1'($urandom_range(0, 1));
      drive(v, ins, we, $urandom_range(0, NREGS - 1), 32'($urandom_range(0, 3)), e);
    end
    chk($sformatf("rand%0d/ended", r), e, 1'b1);
    finish_check($sformatf("rand%0d", r));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit e;
    vecs[0] = '{32'd5, 32'd10, 32'd15, 0, 1'b0, 0, 1'b1};
    vecs[1] = '{32'd5, 32'd11, 32'd14, 2, 1'b1, 2, 1'b0};
    vecs[2] = '{32'd4, 32'd10, 32'd15, 1, 1'b1, 1, 1'b0};
    vecs[3] = '{32'd5, 32'd10, 32'd16, 1, 1'b1, 3, 1'b0};

    model_clear_table();
    for (int i = 0; i < NREGS; i++) m_sh[i] = '0;
    m_cyc = 0;
    m_tmo = 1'b0;

    reset = 1'b0;
    step();
    step();
    check_all_zero("reset_outputs");
    reset = 1'b1;
    step();

    load(1, 32'd5, 1);
    load(2, 32'd10, 1);
    load(3, 32'd15, 1);

    // table-driven halt runs: writes x1..x3, three nops, halt at cyc 6
    for (int t = 0; t < 4; t++) begin
      begin_run();
      drive(1, NOP, 1, 1, vecs[t].w1, e);
      drive(1, NOP, 1, 2, vecs[t].w2, e);
      drive(1, NOP, 1, 3, vecs[t].w3, e);
      for (int i = 0; i < 3; i++) drive(1, NOP, 0, 0, 0, e);
      drive(1, HALT, 0, 0, 0, e);
      finish_check($sformatf("vec%0d", t));
      chk($sformatf("vec%0d/t_check", t), a_chk, 3);
      chk($sformatf("vec%0d/t_fail", t), a_fail, vecs[t].fails);
      chk($sformatf("vec%0d/t_ffv", t), a_ffv, vecs[t].ffv);
      chk($sformatf("vec%0d/t_ffi", t), a_ffi, vecs[t].ffi);
      chk($sformatf("vec%0d/t_pass", t), a_pass, vecs[t].ok);
      chk($sformatf("vec%0d/t_green", t), a_green, vecs[t].ok);
    end

    // early halt at cyc 3 ignored, then timeout on the 50th retired instruction
    begin_run();
    drive(1, NOP, 1, 1, 32'd5, e);
    drive(1, NOP, 1, 2, 32'd10, e);
    drive(1, NOP, 1, 3, 32'd15, e);
    drive(1, HALT, 0, 0, 0, e);
    chk("early_halt/busy", a_busy, 1'b1);
    for (int c = 0; c < 200 && !e; c++) drive(1'($urandom_range(0, 1)), NOP, 0, 0, 0, e);
    finish_check("timeout");
    chk("timeout/t_flag", a_timeout, 1'b1);
    chk("timeout/t_pass_fail_policy", a_pass, 1'b0);
    chk("timeout/t_pass_nofail_policy", b_pass, 1'b1);

    // x0 always compares as 0; write in halt cycle is applied
    load(0, 32'd0, 1);
    load(5, 32'd7, 1);
    x0_run();
    finish_check("x0_ok");
    chk("x0_ok/t_check", a_chk, 5);
    chk("x0_ok/t_pass", a_pass, 1'b1);
    load(0, 32'h1234, 1);
    x0_run();
    finish_check("x0_bad");
    chk("x0_bad/t_ffi", a_ffi, 0);
    chk("x0_bad/t_fail", a_fail, 1);
    load(0, 32'd0, 1);

    // start and exp_we during RUN are ignored
    begin_run();
    drive(1, NOP, 1, 1, 32'd5, e);
    start = 1'b1;
    exp_we = 1'b1; exp_idx = AW'(2); exp_data = 32'd99; exp_en = 1'b1;
    drive(1, NOP, 1, 2, 32'd10, e);
    start = 1'b0;
    exp_we = 1'b0;
    drive(1, NOP, 1, 3, 32'd15, e);
    drive(1, NOP, 1, 5, 32'd7, e);
    for (int i = 0; i < 3; i++) drive(1, NOP, 0, 0, 0, e);
    drive(1, HALT, 0, 0, 0, e);
    finish_check("run_ignores");
    chk("run_ignores/t_pass", a_pass, 1'b1);

    for (int r = 0; r < 8; r++) random_run(r);

    // reset mid-SCAN, then empty table, then reload and rerun from DONE
    load(1, 32'd5, 1);
    good_run();
    for (int i = 0; i < 5; i++) step();
    chk("midscan/busy_before", a_busy, 1'b1);
    reset = 1'b0;
    step();
    check_all_zero("midscan/reset_outputs");
    reset = 1'b1;
    model_clear_table();
    good_run();
    finish_check("empty");
    chk("empty/t_check", a_chk, 0);
    chk("empty/t_pass", a_pass, 1'b1);
    load(1, 32'd5, 1);
    load(2, 32'd10, 1);
    load(3, 32'd15, 1);
    good_run();
    finish_check("reload");
    good_run();
    finish_check("rerun");
    chk("rerun/t_check", a_chk, 3);
    chk("rerun/t_pass", a_pass, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
